// File: rtl/debug_pkg.sv
// Shared types and constants for the Z80 debug capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: trigger FSM state encoding, default snapshot line,
// v8_e status bit positions, and a saturating counter increment.
package debug_pkg;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HELD  = 2'd2
  } trig_state_e;

  // Below the overlay rows, so a refresh never lands on a visible line.
  localparam logic [8:0]  SNAP_LINE_DEF = 9'd248;

  // Counters are 16 bits so they drop straight into a v16 field.
  localparam int          CNT_W   = 16;
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  // Bit positions inside the v8_e status byte.
  localparam int V8E_FREEZE_BIT = 0;
  localparam int V8E_ARMED_BIT  = 1;
  localparam int V8E_HIT_BIT    = 2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_edge_det.sv
// One-shot event detector for a single Z80 bus condition.
// Latency: combinational pulse in the clk where the condition first appears.
// Backpressure: none; the condition is only sampled while i_cpuen is high.
//
// Ports: i_clk, i_rst (sync, active high), i_cpuen (bus sample enable),
//        i_cond (decoded strobe condition), o_evt (one pulse per bus cycle).
module bus_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cpuen,
  input  logic i_cond,
  output logic o_evt
);

  // Condition as seen at the previous cpuen sample, not the previous clk,
  // so a strobe held across many enable gaps still fires once.
  logic r_cond_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cond_q <= 1'b0;
    end else if (i_cpuen) begin
      r_cond_q <= i_cond;
    end
  end

  assign o_evt = i_cpuen & i_cond & ~r_cond_q;

endmodule

// File: rtl/debug_capture.sv
// Z80 bus probe feeding the hex debug overlay: live shadows, per-frame display copy.
// Latency: display outputs update 1 clk after the snap clk or the trigger clk.
// Backpressure: none; the probe only observes the bus and never stalls it.
//
// Inputs : i_clk, i_rst (sync, active high), i_cpuen, i_a, i_din, i_dout,
//          i_mreq_n/i_iorq_n/i_rd_n/i_wr_n/i_m1_n, i_hc, i_vc, i_freeze,
//          i_trig_addr, i_trig_arm, i_trig_clear.
// Outputs: o_v16_a..o_v16_h, o_v8_a..o_v8_h (overlay fields), o_trig_hit.
// Build option: DEBUG_CAPTURE_TRIGGER_EN enables the breakpoint trigger FSM;
//               without it the block stays in FREE and the trigger fields read 0.
module debug_capture
  import debug_pkg::*;
#(
  parameter logic [8:0] SNAP_LINE = SNAP_LINE_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpuen,
  input  logic [15:0] i_a,
  input  logic [7:0]  i_din,
  input  logic [7:0]  i_dout,
  input  logic        i_mreq_n,
  input  logic        i_iorq_n,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic        i_m1_n,
  input  logic [8:0]  i_hc,
  input  logic [8:0]  i_vc,
  input  logic        i_freeze,
  input  logic [15:0] i_trig_addr,
  input  logic        i_trig_arm,
  input  logic        i_trig_clear,
  output logic [15:0] o_v16_a,
  output logic [15:0] o_v16_b,
  output logic [15:0] o_v16_c,
  output logic [15:0] o_v16_d,
  output logic [15:0] o_v16_e,
  output logic [15:0] o_v16_f,
  output logic [15:0] o_v16_g,
  output logic [15:0] o_v16_h,
  output logic [7:0]  o_v8_a,
  output logic [7:0]  o_v8_b,
  output logic [7:0]  o_v8_c,
  output logic [7:0]  o_v8_d,
  output logic [7:0]  o_v8_e,
  output logic [7:0]  o_v8_f,
  output logic [7:0]  o_v8_g,
  output logic [7:0]  o_v8_h,
  output logic        o_trig_hit
);

  // ---------------- bus event detection ----------------
  logic w_ev_fetch, w_ev_mwr, w_ev_iord, w_ev_iowr;

  // Interrupt acknowledge drives IORQ with M1 low; it is not an I/O read.
  bus_edge_det u_det_fetch (.i_clk(i_clk), .i_rst(i_rst), .i_cpuen(i_cpuen),
    .i_cond(~i_m1_n & ~i_mreq_n & ~i_rd_n), .o_evt(w_ev_fetch));
  bus_edge_det u_det_mwr   (.i_clk(i_clk), .i_rst(i_rst), .i_cpuen(i_cpuen),
    .i_cond(~i_mreq_n & ~i_wr_n),           .o_evt(w_ev_mwr));
  bus_edge_det u_det_iord  (.i_clk(i_clk), .i_rst(i_rst), .i_cpuen(i_cpuen),
    .i_cond(~i_iorq_n & ~i_rd_n & i_m1_n),  .o_evt(w_ev_iord));
  bus_edge_det u_det_iowr  (.i_clk(i_clk), .i_rst(i_rst), .i_cpuen(i_cpuen),
    .i_cond(~i_iorq_n & ~i_wr_n),           .o_evt(w_ev_iowr));

  // ---------------- snapshot strobe ----------------
  logic w_snap_cond, r_snap_prev, w_snap;
  assign w_snap_cond = (i_vc == SNAP_LINE) && (i_hc == 9'd0);
  assign w_snap      = w_snap_cond & ~r_snap_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_snap_prev <= 1'b0;
    else       r_snap_prev <= w_snap_cond;
  end

  // ---------------- trigger FSM ----------------
  trig_state_e w_state;
  logic        w_hit;

`ifdef DEBUG_CAPTURE_TRIGGER_EN
  trig_state_e r_state, w_state_nxt;
  logic [15:0] r_hit_pc, r_since_hit;

  // Clear beats a same-clk hit, so the hit is qualified with ~clear.
  assign w_hit   = (r_state == ST_ARMED) & w_ev_fetch & (i_a == i_trig_addr) & ~i_trig_clear;
  assign w_state = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_FREE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FREE:  if (i_trig_arm && !i_trig_clear) w_state_nxt = ST_ARMED;
      ST_ARMED: if (i_trig_clear) w_state_nxt = ST_FREE;
                else if (w_hit) w_state_nxt = ST_HELD;
      ST_HELD:  if (i_trig_clear) w_state_nxt = ST_FREE;
      default:  w_state_nxt = ST_FREE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_pc    <= 16'd0;
      r_since_hit <= 16'd0;
    end else if (i_trig_clear) begin
      r_since_hit <= 16'd0;
    end else if (w_hit) begin
      r_hit_pc    <= i_a;
      r_since_hit <= 16'd0;
    end else if ((r_state == ST_HELD) && w_snap) begin
      r_since_hit <= sat_inc(r_since_hit);
    end
  end

  assign o_trig_hit = (r_state == ST_HELD);
  assign o_v16_g    = r_hit_pc;
  assign o_v16_h    = r_since_hit;
`else
  logic w_unused_trig;
  assign w_unused_trig = ^{i_trig_addr, i_trig_arm, i_trig_clear};
  assign w_state    = ST_FREE;
  assign w_hit      = 1'b0;
  assign o_trig_hit = 1'b0;
  assign o_v16_g    = 16'd0;
  assign o_v16_h    = 16'd0;
`endif

  // ---------------- live shadows ----------------
  logic [15:0]      r_pc_s, r_mwa_s, r_ioa_r_s, r_ioa_w_s, r_frame_s;
  logic [7:0]       r_op_s, r_mwd_s, r_iod_r_s, r_iod_w_s;
  logic [CNT_W-1:0] r_m1cnt_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_s <= '0; r_op_s <= '0; r_mwa_s <= '0; r_mwd_s <= '0;
      r_ioa_r_s <= '0; r_iod_r_s <= '0; r_ioa_w_s <= '0; r_iod_w_s <= '0;
      r_m1cnt_s <= '0; r_frame_s <= '0;
    end else begin
      if (w_ev_fetch) begin r_pc_s <= i_a;    r_op_s <= i_din;     end
      if (w_ev_mwr)   begin r_mwa_s <= i_a;   r_mwd_s <= i_dout;   end
      if (w_ev_iord)  begin r_ioa_r_s <= i_a; r_iod_r_s <= i_din;  end
      if (w_ev_iowr)  begin r_ioa_w_s <= i_a; r_iod_w_s <= i_dout; end
      // The per-frame M1 count restarts at snap; a fetch in that clk is
      // the first one of the new frame.
      if (w_snap)          r_m1cnt_s <= w_ev_fetch ? 16'd1 : 16'd0;
      else if (w_ev_fetch) r_m1cnt_s <= sat_inc(r_m1cnt_s);
      if (w_snap)          r_frame_s <= r_frame_s + 16'd1;
    end
  end

  // ---------------- display registers ----------------
  logic [15:0] r_pc_d, r_mwa_d, r_ioa_r_d, r_ioa_w_d, r_m1cnt_d, r_frame_d;
  logic [7:0]  r_op_d, r_mwd_d, r_iod_r_d, r_iod_w_d;
  logic        r_freeze_q, w_copy;

  assign w_copy = w_snap & (w_state == ST_FREE) & ~i_freeze;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_d <= '0; r_op_d <= '0; r_mwa_d <= '0; r_mwd_d <= '0;
      r_ioa_r_d <= '0; r_iod_r_d <= '0; r_ioa_w_d <= '0; r_iod_w_d <= '0;
      r_m1cnt_d <= '0; r_frame_d <= '0; r_freeze_q <= 1'b0;
    end else begin
      r_freeze_q <= i_freeze;
      if (w_hit || w_copy) begin
        r_mwa_d   <= r_mwa_s;   r_mwd_d   <= r_mwd_s;
        r_ioa_r_d <= r_ioa_r_s; r_iod_r_d <= r_iod_r_s;
        r_ioa_w_d <= r_ioa_w_s; r_iod_w_d <= r_iod_w_s;
        r_m1cnt_d <= r_m1cnt_s;
      end
      if (w_hit) begin
        // The breakpoint fetch itself has not reached the shadows yet.
        r_pc_d    <= i_a;
        r_op_d    <= i_din;
        r_frame_d <= r_frame_s;
      end else if (w_copy) begin
        r_pc_d    <= r_pc_s;
        r_op_d    <= r_op_s;
        // Show the count including the frame boundary being taken now.
        r_frame_d <= r_frame_s + 16'd1;
      end
    end
  end

  logic [7:0] w_v8_e;
  always_comb begin
    w_v8_e                 = 8'h00;
    w_v8_e[V8E_FREEZE_BIT] = r_freeze_q;
    w_v8_e[V8E_ARMED_BIT]  = (w_state == ST_ARMED);
    w_v8_e[V8E_HIT_BIT]    = (w_state == ST_HELD);
  end

  assign o_v16_a = r_pc_d;
  assign o_v16_b = r_mwa_d;
  assign o_v16_c = r_ioa_r_d;
  assign o_v16_d = r_ioa_w_d;
  assign o_v16_e = r_m1cnt_d;
  assign o_v16_f = r_frame_d;
  assign o_v8_a  = r_op_d;
  assign o_v8_b  = r_mwd_d;
  assign o_v8_c  = r_iod_r_d;
  assign o_v8_d  = r_iod_w_d;
  assign o_v8_e  = w_v8_e;
  assign o_v8_f  = 8'h00;
  assign o_v8_g  = 8'h00;
  assign o_v8_h  = 8'h00;

endmodule

// File: tb/tb_debug_capture.sv
// Bench for debug_capture: directed scenarios, then random bus traffic.
// Every clk the reference model pushes the expected overlay fields into a
// queue; a monitor on the falling edge pops and compares them.
`timescale 1ns/1ps
module tb_debug_capture;

`ifdef DEBUG_CAPTURE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpuen, mreq_n, iorq_n, rd_n, wr_n, m1_n, freeze, trig_arm, trig_clear;
  logic [15:0] a, trig_addr;
  logic [7:0]  din, dout;
  logic [8:0]  hc, vc;
  logic [15:0] v16_a, v16_b, v16_c, v16_d, v16_e, v16_f, v16_g, v16_h;
  logic [7:0]  v8_a, v8_b, v8_c, v8_d, v8_e, v8_f, v8_g, v8_h;
  logic        trig_hit;

  debug_capture dut (
    .i_clk(clk), .i_rst(rst), .i_cpuen(cpuen), .i_a(a), .i_din(din), .i_dout(dout),
    .i_mreq_n(mreq_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n), .i_m1_n(m1_n),
    .i_hc(hc), .i_vc(vc), .i_freeze(freeze), .i_trig_addr(trig_addr),
    .i_trig_arm(trig_arm), .i_trig_clear(trig_clear),
    .o_v16_a(v16_a), .o_v16_b(v16_b), .o_v16_c(v16_c), .o_v16_d(v16_d),
    .o_v16_e(v16_e), .o_v16_f(v16_f), .o_v16_g(v16_g), .o_v16_h(v16_h),
    .o_v8_a(v8_a), .o_v8_b(v8_b), .o_v8_c(v8_c), .o_v8_d(v8_d),
    .o_v8_e(v8_e), .o_v8_f(v8_f), .o_v8_g(v8_g), .o_v8_h(v8_h),
    .o_trig_hit(trig_hit)
  );

  typedef struct packed {
    logic [7:0][15:0] v16;
    logic [7:0][7:0]  v8;
    logic             hit;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  // Last sampled bus conditions, previous snap-line condition.
  bit          p_f, p_m, p_r, p_w, p_s;
  // Live values since the last frame.
  logic [15:0] m_pc, m_mwa, m_iar, m_iaw, m_m1, m_frame;
  logic [7:0]  m_op, m_mwd, m_idr, m_idw;
  // What the overlay should be showing.
  logic [15:0] d_pc, d_mwa, d_iar, d_iaw, d_m1, d_frame, m_hpc, m_since;
  logic [7:0]  d_op, d_mwd, d_idr, d_idw;
  int          m_st;   // 0 free, 1 armed, 2 held
  bit          m_frz;

  task automatic model_clk();
    bit cf, cm, cr, cw, ef, em, er, ew, sc, snap, hit;
    if (rst) begin
      {p_f, p_m, p_r, p_w, p_s} = '0;
      {m_pc, m_mwa, m_iar, m_iaw, m_m1, m_frame} = '0;
      {m_op, m_mwd, m_idr, m_idw} = '0;
      {d_pc, d_mwa, d_iar, d_iaw, d_m1, d_frame, m_hpc, m_since} = '0;
      {d_op, d_mwd, d_idr, d_idw} = '0;
      m_st = 0; m_frz = 1'b0;
    end else begin
      cf = !m1_n && !mreq_n && !rd_n;
      cm = !mreq_n && !wr_n;
      cr = !iorq_n && !rd_n && m1_n;
      cw = !iorq_n && !wr_n;
      ef = cpuen && cf && !p_f;
      em = cpuen && cm && !p_m;
      er = cpuen && cr && !p_r;
      ew = cpuen && cw && !p_w;
      if (cpuen) begin p_f = cf; p_m = cm; p_r = cr; p_w = cw; end
      sc   = (vc == 9'd248) && (hc == 9'd0);
      snap = sc && !p_s;
      p_s  = sc;
      hit  = TRIG && m_st == 1 && ef && a == trig_addr && !trig_clear;
      if (hit || (snap && m_st == 0 && !freeze)) begin
        d_mwa = m_mwa; d_mwd = m_mwd; d_iar = m_iar; d_idr = m_idr;
        d_iaw = m_iaw; d_idw = m_idw; d_m1 = m_m1;
        d_pc    = hit ? a : m_pc;
        d_op    = hit ? din : m_op;
        d_frame = hit ? m_frame : m_frame + 16'd1;
      end
      if (hit) begin m_hpc = a; m_since = 16'd0; end
      if (TRIG && trig_clear) m_since = 16'd0;
      else if (m_st == 2 && snap && m_since != 16'hFFFF) m_since = m_since + 16'd1;
      if (TRIG) begin
        if (trig_clear)              m_st = 0;
        else if (m_st == 0 && trig_arm) m_st = 1;
        else if (hit)                m_st = 2;
      end
      if (ef) begin m_pc = a;  m_op = din;   end
      if (em) begin m_mwa = a; m_mwd = dout; end
      if (er) begin m_iar = a; m_idr = din;  end
      if (ew) begin m_iaw = a; m_idw = dout; end
      if (snap) begin
        m_frame = m_frame + 16'd1;
        m_m1    = ef ? 16'd1 : 16'd0;
      end else if (ef && m_m1 != 16'hFFFF) begin
        m_m1 = m_m1 + 16'd1;
      end
      m_frz = freeze;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.v16 = {m_since, m_hpc, d_frame, d_m1, d_iaw, d_iar, d_mwa, d_pc};
    o.v8  = {24'h0, {5'b0, m_st == 2, m_st == 1, m_frz}, d_idw, d_idr, d_mwd, d_op};
    o.hit = (m_st == 2);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.v16 = {v16_h, v16_g, v16_f, v16_e, v16_d, v16_c, v16_b, v16_a};
    o.v8  = {v8_h, v8_g, v8_f, v8_e, v8_d, v8_c, v8_b, v8_a};
    o.hit = trig_hit;
    return o;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    obs_t act, exp_o;
    string nm;
    while (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      act   = dut_obs();
      checks++;
      if (act !== exp_o) begin
        errors++;
        nm = "trig_hit";
        for (int i = 7; i >= 0; i--) begin
          if (act.v8[i]  !== exp_o.v8[i])  nm = $sformatf("v8_%c", 8'h61 + i);
        end
        for (int i = 7; i >= 0; i--) begin
          if (act.v16[i] !== exp_o.v16[i]) nm = $sformatf("v16_%c", 8'h61 + i);
        end
        $display("FAIL scoreboard t=%0t first field %s: got %h want %h", $time, nm, act, exp_o);
      end
    end
  end

  task automatic spot(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int n_snap = 0;

  task automatic step();
    model_clk();
    @(posedge clk); #1;
    exp_q.push_back(model_obs());
  endtask

  // 0 idle, 1 fetch, 2 mem read, 3 mem write, 4 io read, 5 io write, 6 int ack
  task automatic set_bus(input int kind);
    mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1;
    case (kind)
      1: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
      2: begin mreq_n = 0; rd_n = 0; end
      3: begin mreq_n = 0; wr_n = 0; end
      4: begin iorq_n = 0; rd_n = 0; end
      5: begin iorq_n = 0; wr_n = 0; end
      6: begin iorq_n = 0; m1_n = 0; rd_n = 0; end
      default: ;
    endcase
  endtask

  task automatic bus_op(input int kind, input logic [15:0] ad, input logic [7:0] d, input int n);
    a = ad; din = d; dout = d; cpuen = 1;
    set_bus(kind);
    repeat (n) step();
    set_bus(0);
    step();
  endtask

  // Snap line held two clks: only one refresh may result.
  task automatic do_snap();
    vc = 9'd248; hc = 9'd0;
    step(); step();
    vc = 9'd0; hc = 9'd5;
    step();
    n_snap++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hold;
    int kind;
    rst = 1; cpuen = 1; a = 0; din = 0; dout = 0; set_bus(0);
    hc = 9'd5; vc = 9'd0; freeze = 0; trig_addr = 16'h1234; trig_arm = 0; trig_clear = 0;
    step(); step();
    rst = 0;
    step();

    // reset with shadows and display loaded
    bus_op(1, 16'h1111, 8'hAA, 2);
    bus_op(3, 16'h2222, 8'hBB, 2);
    do_snap();
    spot("pre_reset_v16_a", v16_a, 16'h1111);
    bus_op(1, 16'h5555, 8'h55, 1);
    rst = 1; step(); rst = 0; n_snap = 0;
    spot("reset_v16_a", v16_a, 16'h0000);
    spot("reset_v16_b", v16_b, 16'h0000);
    spot("reset_v8_a", {8'h0, v8_a}, 16'h0000);
    spot("reset_hit", {15'h0, trig_hit}, 16'h0000);
    do_snap();
    spot("empty_snap_v16_f", v16_f, 16'h0001);
    spot("empty_snap_v16_a", v16_a, 16'h0000);
    spot("empty_snap_v16_e", v16_e, 16'h0000);

    // fetch held 4 clks counts once
    bus_op(1, 16'h8000, 8'h3E, 4);
    do_snap();
    spot("fetch_v16_a", v16_a, 16'h8000);
    spot("fetch_v8_a", {8'h0, v8_a}, 16'h003E);
    spot("fetch_v16_e", v16_e, 16'h0001);
    bus_op(1, 16'h9000, 8'hC3, 2);
    spot("no_tear_v16_a", v16_a, 16'h8000);
    do_snap();
    spot("next_snap_v16_a", v16_a, 16'h9000);

    // memory write held over 6 cpuen samples with gaps
    a = 16'h4000; dout = 8'h5A; set_bus(3);
    for (int i = 0; i < 12; i++) begin cpuen = (i % 2 == 0); step(); end
    cpuen = 1; set_bus(0); step();
    do_snap();
    spot("mwr_v16_b", v16_b, 16'h4000);
    spot("mwr_v8_b", {8'h0, v8_b}, 16'h005A);
    spot("mwr_v16_e", v16_e, 16'h0000);

    // I/O write then read
    bus_op(5, 16'h00FE, 8'h07, 3);
    bus_op(4, 16'h7FFE, 8'hBF, 3);
    do_snap();
    spot("iowr_v16_d", v16_d, 16'h00FE);
    spot("iowr_v8_d", {8'h0, v8_d}, 16'h0007);
    spot("iord_v16_c", v16_c, 16'h7FFE);
    spot("iord_v8_c", {8'h0, v8_c}, 16'h00BF);

    // freeze across 3 snaps
    spot("frame_count", v16_f, 16'(n_snap));
    freeze = 1; step();
    spot("freeze_bit", {8'h0, v8_e}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      bus_op(1, 16'hA000 + 16'(i), 8'h00, 1);
      do_snap();
    end
    spot("freeze_v16_a", v16_a, 16'h9000);
    spot("freeze_v16_f", v16_f, 16'(n_snap - 3));
    freeze = 0;
    do_snap();
    spot("thaw_v16_f", v16_f, 16'(n_snap));
    spot("thaw_v16_a", v16_a, 16'hA002);

    // breakpoint trigger
    trig_addr = 16'h1234;
    trig_arm = 1; step(); trig_arm = 0;
    bus_op(1, 16'h1234, 8'h77, 2);
`ifdef DEBUG_CAPTURE_TRIGGER_EN
    spot("hit_flag", {15'h0, trig_hit}, 16'h0001);
    spot("hit_v16_g", v16_g, 16'h1234);
    spot("hit_v16_a", v16_a, 16'h1234);
    spot("hit_v8_e", {8'h0, v8_e}, 16'h0004);
    bus_op(1, 16'h2222, 8'h11, 2);
    do_snap(); do_snap();
    spot("held_v16_a", v16_a, 16'h1234);
    spot("held_v16_h", v16_h, 16'h0002);
    trig_clear = 1; step(); trig_clear = 0;
    spot("clear_hit", {15'h0, trig_hit}, 16'h0000);
    spot("clear_v16_h", v16_h, 16'h0000);
    do_snap();
    spot("resume_v16_a", v16_a, 16'h2222);
`else
    spot("notrig_hit", {15'h0, trig_hit}, 16'h0000);
    spot("notrig_v16_g", v16_g, 16'h0000);
    do_snap();
    spot("notrig_v16_a", v16_a, 16'h1234);
    spot("notrig_v8_e", {8'h0, v8_e}, 16'h0000);
`endif

    // random traffic
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (hold <= 0) begin
        kind = $urandom_range(0, 6);
        hold = $urandom_range(1, 5);
        a    = ($urandom_range(0, 3) == 0) ? trig_addr : 16'($urandom);
        din  = 8'($urandom);
        dout = 8'($urandom);
        set_bus(kind);
      end
      hold--;
      cpuen = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       begin vc = 9'd248; hc = 9'd0; end
        1:       begin vc = 9'd248; hc = 9'($urandom); end
        default: begin vc = 9'($urandom); hc = 9'($urandom); end
      endcase
      if ($urandom_range(0, 39) == 0) freeze = ~freeze;
      trig_arm   = ($urandom_range(0, 19) == 0);
      trig_clear = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; trig_arm = 0; trig_clear = 0;
    step();
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
